// File: rtl/gshare_pattern_history_table.sv
// Tagged, multi-lane saturating-counter direction predictor with a speculative global
// history register; a valid sweep after reset keeps lookups quiet until every entry is cleared.
module gshare_pattern_history_table #(
   parameter int ENTRIES = 256,
   parameter int LANES   = 4,
   parameter int CTR_W   = 2,
   parameter int TAG_W   = 8,
   parameter int GHR_W   = 8,
   parameter int USE_GHR = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [31:0]              PCR_VAddr_i,
   output logic                     ready_o,
   output logic [LANES-1:0]         pred_take_o,
   output logic [LANES-1:0]         hit_o,
   output logic [LANES*CTR_W-1:0]   ctr_o,
   output logic [GHR_W-1:0]         ghr_snap_o,
   input  logic                     spec_valid_i,
   input  logic                     spec_taken_i,
   input  logic                     upd_valid_i,
   input  logic [31:0]              upd_vaddr_i,
   input  logic                     upd_hit_i,
   input  logic [CTR_W-1:0]         upd_ctr_i,
   input  logic                     upd_taken_i,
   input  logic [GHR_W-1:0]         upd_ghr_i,
   input  logic                     repair_i
);
   localparam int IDX_W  = $clog2(ENTRIES);
   localparam int LB     = $clog2(LANES);
   localparam int ENT_W  = 1 + TAG_W + CTR_W;
   localparam int TAG_LO = IDX_W + LB + 2;
   localparam int FOLD_N = (GHR_W + IDX_W - 1) / IDX_W;
   localparam int PAD_W  = FOLD_N * IDX_W;
   localparam logic [CTR_W-1:0] WEAK_T = {1'b1, {(CTR_W-1){1'b0}}};
   localparam logic [CTR_W-1:0] WEAK_N = {1'b0, {(CTR_W-1){1'b1}}};

   typedef enum logic {S_CLEAR, S_RUN} state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  ptr_q, ptr_d;
   logic [GHR_W-1:0]  ghr_q, ghr_d;
   logic [GHR_W-1:0]  ghr_snap_q, ghr_snap_d;
   logic              run_q, run_d;
   logic [TAG_W-1:0]  lk_tag_q, lk_tag_d;
   logic [ENT_W-1:0]  wr_entry_q, wr_entry_d;
   logic [IDX_W-1:0]  lk_idx, upd_idx, wr_idx;
   logic [TAG_W-1:0]  lk_tag, upd_tag;
   logic [LB-1:0]     upd_bank;
   logic [CTR_W-1:0]  new_ctr;
   logic [ENT_W-1:0]  wr_entry;
   logic [LANES-1:0]  wr_sel;
   logic              clearing;
   logic              unused_bits;

   // XOR the history down to IDX_W bits, zero-padding the last chunk.
   function automatic logic [IDX_W-1:0] fold(input logic [GHR_W-1:0] g);
      logic [PAD_W-1:0] gp;
      logic [IDX_W-1:0] r;
      gp = PAD_W'(g);
      r  = '0;
      for (int c = 0; c < FOLD_N; c++) r = r ^ gp[c*IDX_W +: IDX_W];
      return r;
   endfunction

   assign clearing   = (state_q == S_CLEAR);
   assign ready_o    = (state_q == S_RUN);
   assign ghr_snap_o = ghr_snap_q;
   assign lk_tag     = PCR_VAddr_i[TAG_LO +: TAG_W];
   assign upd_tag    = upd_vaddr_i[TAG_LO +: TAG_W];
   assign upd_bank   = upd_vaddr_i[2 +: LB];
   assign lk_idx     = PCR_VAddr_i[LB+2 +: IDX_W] ^ ((USE_GHR != 0) ? fold(ghr_q) : '0);
   assign upd_idx    = upd_vaddr_i[LB+2 +: IDX_W] ^ ((USE_GHR != 0) ? fold(upd_ghr_i) : '0);
   assign unused_bits = ^{PCR_VAddr_i[31:TAG_LO+TAG_W], PCR_VAddr_i[LB+1:0],
                          upd_vaddr_i[31:TAG_LO+TAG_W], upd_vaddr_i[1:0]};

   always_comb begin
      new_ctr = upd_ctr_i;
      if (upd_hit_i) begin
         if (upd_taken_i) begin
            if (upd_ctr_i != '1) new_ctr = upd_ctr_i + CTR_W'(1);
         end else begin
            if (upd_ctr_i != '0) new_ctr = upd_ctr_i - CTR_W'(1);
         end
      end else begin
         new_ctr = upd_taken_i ? WEAK_T : WEAK_N;
      end
   end

   // One write port per bank: the sweep owns it while clearing, the back end afterwards.
   always_comb begin
      wr_idx   = clearing ? ptr_q : upd_idx;
      wr_entry = clearing ? '0 : {1'b1, upd_tag, new_ctr};
      for (int l = 0; l < LANES; l++) begin
         wr_sel[l] = clearing || (upd_valid_i && (upd_bank == LB'(l)));
      end
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      ghr_d      = ghr_q;
      ghr_snap_d = ghr_q;
      run_d      = (state_q == S_RUN);
      lk_tag_d   = lk_tag;
      wr_entry_d = wr_entry;
      if (state_q == S_CLEAR) begin
         ptr_d = ptr_q + IDX_W'(1);
         if (ptr_q == IDX_W'(ENTRIES-1)) state_d = S_RUN;
      end
      if (repair_i) begin
         ghr_d = {upd_ghr_i[GHR_W-2:0], upd_taken_i};
      end else if (spec_valid_i) begin
         ghr_d = {ghr_q[GHR_W-2:0], spec_taken_i};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_CLEAR;
         ptr_q      <= '0;
         ghr_q      <= '0;
         ghr_snap_q <= '0;
         run_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         ghr_q      <= ghr_d;
         ghr_snap_q <= ghr_snap_d;
         run_q      <= run_d;
      end
   end

   always_ff @(posedge clk) begin
      lk_tag_q   <= lk_tag_d;
      wr_entry_q <= wr_entry_d;
   end

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_bank
         logic [ENT_W-1:0] mem [ENTRIES];
         logic [ENT_W-1:0] rd_q;
         logic [ENT_W-1:0] ent;
         logic             byp_q, byp_d;

         assign byp_d = wr_sel[gi] && (wr_idx == lk_idx);

         always_ff @(posedge clk) begin
            if (wr_sel[gi]) mem[wr_idx] <= wr_entry;
            rd_q  <= mem[lk_idx];
            byp_q <= byp_d;
         end

         // run_q masks the sweep period and gives zero outputs straight out of reset.
         assign ent                      = byp_q ? wr_entry_q : rd_q;
         assign hit_o[gi]                = run_q && ent[ENT_W-1] && (ent[CTR_W +: TAG_W] == lk_tag_q);
         assign ctr_o[gi*CTR_W +: CTR_W] = run_q ? ent[CTR_W-1:0] : '0;
         assign pred_take_o[gi]          = run_q && ent[CTR_W-1];
      end
   endgenerate
endmodule

// File: tb/tb_gshare_pattern_history_table.sv
// Directed bench for gshare_pattern_history_table: sweep, allocate, saturation,
// same-cycle bypass, GHR push/repair, hashed indexing, tag miss and mid-run reset.
module tb_gshare_pattern_history_table;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] PCR_VAddr_i;
   logic        ready_o;
   logic [3:0]  pred_take_o;
   logic [3:0]  hit_o;
   logic [7:0]  ctr_o;
   logic [7:0]  ghr_snap_o;
   logic        spec_valid_i, spec_taken_i;
   logic        upd_valid_i;
   logic [31:0] upd_vaddr_i;
   logic        upd_hit_i;
   logic [1:0]  upd_ctr_i;
   logic        upd_taken_i;
   logic [7:0]  upd_ghr_i;
   logic        repair_i;

   int n_checks = 0;
   int n_fail   = 0;

   gshare_pattern_history_table #(
      .ENTRIES(256), .LANES(4), .CTR_W(2), .TAG_W(8), .GHR_W(8), .USE_GHR(1)
   ) dut (
      .clk(clk), .rst(rst), .PCR_VAddr_i(PCR_VAddr_i),
      .ready_o(ready_o), .pred_take_o(pred_take_o), .hit_o(hit_o), .ctr_o(ctr_o),
      .ghr_snap_o(ghr_snap_o), .spec_valid_i(spec_valid_i), .spec_taken_i(spec_taken_i),
      .upd_valid_i(upd_valid_i), .upd_vaddr_i(upd_vaddr_i), .upd_hit_i(upd_hit_i),
      .upd_ctr_i(upd_ctr_i), .upd_taken_i(upd_taken_i), .upd_ghr_i(upd_ghr_i),
      .repair_i(repair_i)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_upd(input logic [31:0] va, input logic hit, input logic [1:0] ctr,
                          input logic tk, input logic [7:0] g);
      upd_valid_i = 1'b1;
      upd_vaddr_i = va;
      upd_hit_i   = hit;
      upd_ctr_i   = ctr;
      upd_taken_i = tk;
      upd_ghr_i   = g;
   endtask

   task automatic clr_upd();
      upd_valid_i = 1'b0;
      upd_hit_i   = 1'b0;
      upd_ctr_i   = 2'b00;
      upd_taken_i = 1'b0;
      upd_ghr_i   = 8'h00;
   endtask

   task automatic test_reset();
      logic exp_rdy;
      rst = 1'b1;
      #2 rst = 1'b0;
      repeat (3) tick();
      n_checks++;
      if ({ready_o, hit_o, pred_take_o, ctr_o, ghr_snap_o} !== 25'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got rdy=%b hit=%b pred=%b ctr=%h ghr=%h required all 0",
                  ready_o, hit_o, pred_take_o, ctr_o, ghr_snap_o);
      end
      rst = 1'b1;
      for (int c = 1; c <= 256; c++) begin
         PCR_VAddr_i = 32'(c) << 4;
         tick();
         exp_rdy = (c >= 256);
         n_checks++;
         if (ready_o !== exp_rdy) begin
            n_fail++;
            $display("FAIL sweep_ready c=%0d: got %b required %b", c, ready_o, exp_rdy);
         end
         n_checks++;
         if (hit_o !== 4'b0000) begin
            n_fail++;
            $display("FAIL sweep_hit c=%0d: got %b required 0000", c, hit_o);
         end
      end
      $display("test_reset done");
   endtask

   task automatic test_allocate();
      set_upd(32'h0000_1234, 1'b0, 2'b00, 1'b1, 8'h00);
      PCR_VAddr_i = 32'h0;
      tick();
      clr_upd();
      PCR_VAddr_i = 32'h0000_1230;
      tick();
      n_checks++;
      if (hit_o !== 4'b0010 || ctr_o !== 8'h08 || pred_take_o !== 4'b0010) begin
         n_fail++;
         $display("FAIL alloc_taken: got hit=%b ctr=%h pred=%b required hit=0010 ctr=08 pred=0010",
                  hit_o, ctr_o, pred_take_o);
      end
      $display("test_allocate: hit=%b ctr=%h pred=%b", hit_o, ctr_o, pred_take_o);
   endtask

   task automatic test_counter();
      PCR_VAddr_i = 32'h0000_0FF0;
      set_upd(32'h0000_2000, 1'b1, 2'b11, 1'b1, 8'h00); tick();
      set_upd(32'h0000_2004, 1'b1, 2'b00, 1'b0, 8'h00); tick();
      set_upd(32'h0000_2008, 1'b1, 2'b01, 1'b1, 8'h00); tick();
      set_upd(32'h0000_200C, 1'b1, 2'b10, 1'b0, 8'h00); tick();
      clr_upd();
      PCR_VAddr_i = 32'h0000_2000;
      tick();
      n_checks++;
      if (hit_o !== 4'b1111 || ctr_o !== 8'h63 || pred_take_o !== 4'b0101) begin
         n_fail++;
         $display("FAIL sat_update: got hit=%b ctr=%h pred=%b required hit=1111 ctr=63 pred=0101",
                  hit_o, ctr_o, pred_take_o);
      end
      $display("test_counter sat: hit=%b ctr=%h pred=%b", hit_o, ctr_o, pred_take_o);
      set_upd(32'h0000_3010, 1'b0, 2'b11, 1'b0, 8'h00);
      tick();
      clr_upd();
      PCR_VAddr_i = 32'h0000_3010;
      tick();
      n_checks++;
      if (hit_o !== 4'b0001 || ctr_o !== 8'h01 || pred_take_o !== 4'b0000) begin
         n_fail++;
         $display("FAIL alloc_not_taken: got hit=%b ctr=%h pred=%b required hit=0001 ctr=01 pred=0000",
                  hit_o, ctr_o, pred_take_o);
      end
      $display("test_counter alloc nt: hit=%b ctr=%h", hit_o, ctr_o);
   endtask

   task automatic test_back_to_back();
      PCR_VAddr_i = 32'h0000_4000;
      set_upd(32'h0000_4008, 1'b0, 2'b00, 1'b1, 8'h00);
      tick();
      n_checks++;
      if (hit_o !== 4'b0100 || ctr_o !== 8'h63) begin
         n_fail++;
         $display("FAIL bypass_alloc: got hit=%b ctr=%h required hit=0100 ctr=63", hit_o, ctr_o);
      end
      set_upd(32'h0000_4008, 1'b1, 2'b10, 1'b1, 8'h00);
      tick();
      n_checks++;
      if (hit_o !== 4'b0100 || ctr_o !== 8'h73) begin
         n_fail++;
         $display("FAIL bypass_inc: got hit=%b ctr=%h required hit=0100 ctr=73", hit_o, ctr_o);
      end
      clr_upd();
      $display("test_back_to_back: hit=%b ctr=%h", hit_o, ctr_o);
   endtask

   task automatic test_tag_miss();
      PCR_VAddr_i = 32'h0003_1230;
      tick();
      n_checks++;
      if (hit_o !== 4'b0000 || ctr_o !== 8'h08 || pred_take_o !== 4'b0010) begin
         n_fail++;
         $display("FAIL tag_miss: got hit=%b ctr=%h pred=%b required hit=0000 ctr=08 pred=0010",
                  hit_o, ctr_o, pred_take_o);
      end
      $display("test_tag_miss: hit=%b ctr=%h pred=%b", hit_o, ctr_o, pred_take_o);
   endtask

   task automatic test_ghr();
      PCR_VAddr_i  = 32'h0;
      spec_valid_i = 1'b1;
      spec_taken_i = 1'b1;
      repeat (3) tick();
      spec_valid_i = 1'b0;
      tick();
      n_checks++;
      if (ghr_snap_o !== 8'h07) begin
         n_fail++;
         $display("FAIL ghr_push: got %h required 07", ghr_snap_o);
      end
      repair_i     = 1'b1;
      upd_ghr_i    = 8'h05;
      upd_taken_i  = 1'b0;
      spec_valid_i = 1'b1;
      tick();
      repair_i     = 1'b0;
      spec_valid_i = 1'b0;
      clr_upd();
      tick();
      n_checks++;
      if (ghr_snap_o !== 8'h0A) begin
         n_fail++;
         $display("FAIL ghr_repair: got %h required 0a", ghr_snap_o);
      end
      $display("test_ghr: snap=%h", ghr_snap_o);
   endtask

   task automatic test_hash();
      PCR_VAddr_i = 32'h0;
      set_upd(32'h0000_5004, 1'b0, 2'b00, 1'b1, 8'h0A);
      tick();
      clr_upd();
      PCR_VAddr_i = 32'h0000_5000;
      tick();
      n_checks++;
      if (hit_o !== 4'b0010 || ctr_o !== 8'h08 || ghr_snap_o !== 8'h0A) begin
         n_fail++;
         $display("FAIL hash_hit: got hit=%b ctr=%h ghr=%h required hit=0010 ctr=08 ghr=0a",
                  hit_o, ctr_o, ghr_snap_o);
      end
      PCR_VAddr_i = 32'h0000_50A0;
      tick();
      n_checks++;
      if (hit_o !== 4'b0000 || ctr_o !== 8'h73) begin
         n_fail++;
         $display("FAIL hash_alias: got hit=%b ctr=%h required hit=0000 ctr=73", hit_o, ctr_o);
      end
      $display("test_hash: hit=%b ctr=%h", hit_o, ctr_o);
   endtask

   task automatic test_reset_mid();
      logic exp_rdy;
      #2 rst = 1'b0;
      #1;
      n_checks++;
      if ({ready_o, hit_o, pred_take_o, ctr_o, ghr_snap_o} !== 25'd0) begin
         n_fail++;
         $display("FAIL midrun_reset: got rdy=%b hit=%b pred=%b ctr=%h ghr=%h required all 0",
                  ready_o, hit_o, pred_take_o, ctr_o, ghr_snap_o);
      end
      tick();
      rst = 1'b1;
      PCR_VAddr_i = 32'h0000_1230;
      for (int c = 1; c <= 256; c++) begin
         tick();
         if (c >= 250) begin
            exp_rdy = (c >= 256);
            n_checks++;
            if (ready_o !== exp_rdy) begin
               n_fail++;
               $display("FAIL resweep_ready c=%0d: got %b required %b", c, ready_o, exp_rdy);
            end
         end
      end
      tick();
      n_checks++;
      if (hit_o !== 4'b0000 || ctr_o !== 8'h00 || ghr_snap_o !== 8'h00) begin
         n_fail++;
         $display("FAIL resweep_cleared: got hit=%b ctr=%h ghr=%h required hit=0000 ctr=00 ghr=00",
                  hit_o, ctr_o, ghr_snap_o);
      end
      $display("test_reset_mid: rdy=%b hit=%b ctr=%h", ready_o, hit_o, ctr_o);
   endtask

   initial begin
      PCR_VAddr_i  = 32'h0;
      spec_valid_i = 1'b0;
      spec_taken_i = 1'b0;
      repair_i     = 1'b0;
      upd_vaddr_i  = 32'h0;
      clr_upd();
      test_reset();
      test_allocate();
      test_counter();
      test_back_to_back();
      test_tag_miss();
      test_ghr();
      test_hash();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
